// File: rtl/cmos_report_pkg.sv
// Shared constants, hex helper and formatter state type for the CMOS frame reporter.
package cmos_report_pkg;

    localparam int unsigned MSG_LEN_LUMA = 25;
    localparam int unsigned MSG_LEN_BASE = 20;

    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_P  = 8'h50;
    localparam logic [7:0] ASCII_Y  = 8'h59;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Upper-case ASCII hex digit for a nibble.
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

    typedef enum logic [1:0] {StIdle, StSend, StWait} fmt_state_e;

endpackage

// File: rtl/cmos_frame_reporter_uart_byte_tx.sv
// 8N1 byte transmitter; O_done pulses in the final cycle of the stop bit so the next
// byte can follow after at most one idle cycle.
module uart_byte_tx #(
    parameter int unsigned CLK_DIV = 365
) (
    input  logic       I_pxl_clk,
    input  logic       I_rst,
    input  logic [7:0] I_data,
    input  logic       I_start,
    output logic       O_done,
    output logic       O_tx
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [3:0]       bit_q;
    logic [8:0]       shift_q;
    logic             active_q;
    logic             tx_q;
    logic             bit_end;

    assign bit_end = active_q && (div_q == DIV_LAST);
    assign O_done  = bit_end && (bit_q == 4'd9);
    assign O_tx    = tx_q;

    // bit_q: 0 = start, 1..8 = data LSB first, 9 = stop
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            div_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '0;
        end else if (!active_q) begin
            if (I_start) begin
                active_q <= 1'b1;
                tx_q     <= 1'b0;
                shift_q  <= {1'b1, I_data};
                div_q    <= '0;
                bit_q    <= 4'd0;
            end
        end else if (bit_end) begin
            div_q <= '0;
            if (bit_q == 4'd9) begin
                active_q <= 1'b0;
                tx_q     <= 1'b1;
            end else begin
                tx_q    <= shift_q[0];
                shift_q <= {1'b1, shift_q[8:1]};
                bit_q   <= bit_q + 4'd1;
            end
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/cmos_frame_reporter.sv
// Per-frame geometry monitor with periodic ASCII report over UART, pixel-clock domain only.
// Define CMOS_REPORT_LUMA_EN to add peak-luma tracking and the " Y=hh" field.
module cmos_frame_reporter #(
    parameter int unsigned CLK_DIV      = 365,
    parameter int unsigned REPORT_EVERY = 16
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst,
    input  logic        I_vsync,
    input  logic        I_href,
    input  logic        I_pix_valid,
    input  logic [15:0] I_pix_data,
    output logic        O_uart_tx,
    output logic        O_busy,
    output logic [15:0] O_frame_cnt,
    output logic        O_overrun
);

    import cmos_report_pkg::*;

`ifdef CMOS_REPORT_LUMA_EN
    localparam int unsigned MSG_LEN = MSG_LEN_LUMA;
`else
    localparam int unsigned MSG_LEN = MSG_LEN_BASE;
`endif
    localparam logic [4:0] LAST_IDX = 5'(MSG_LEN - 1);

    logic        vsync_q, href_q;
    logic        vs_rise, href_rise, href_fall, pix_ok;
    logic [11:0] line_cnt_q, px_cnt_q, last_px_q, px_cnt_inc;
    logic [15:0] frame_cnt_q, frame_cnt_inc;
    logic        frame_done, report_due, load_report;
    logic [15:0] rep_frame_q;
    logic [11:0] rep_line_q, rep_px_q;
    logic        overrun_q;

    fmt_state_e  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        tx_start, tx_done;
    logic [7:0]  msg_byte;

    assign vs_rise       = I_vsync & ~vsync_q;
    assign href_rise     = I_href & ~href_q;
    assign href_fall     = ~I_href & href_q;
    assign pix_ok        = I_pix_valid & href_q;
    assign px_cnt_inc    = (pix_ok && px_cnt_q != 12'hFFF) ? px_cnt_q + 12'd1 : px_cnt_q;
    assign frame_done    = vs_rise && (line_cnt_q != 12'd0);
    assign frame_cnt_inc = frame_cnt_q + 16'd1;
    assign report_due    = frame_done && ((32'(frame_cnt_inc) % REPORT_EVERY) == 32'd0);
    assign load_report   = report_due && (state_q == StIdle);

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            frame_cnt_q <= '0;
            line_cnt_q  <= '0;
            px_cnt_q    <= '0;
            last_px_q   <= '0;
            rep_frame_q <= '0;
            rep_line_q  <= '0;
            rep_px_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            vsync_q <= I_vsync;
            href_q  <= I_href;
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_inc;
            end
            // Frame boundary wins; a coincident href rise is the first line of the new frame.
            if (frame_done) begin
                line_cnt_q <= href_rise ? 12'd1 : 12'd0;
            end else if (href_rise && line_cnt_q != 12'hFFF) begin
                line_cnt_q <= line_cnt_q + 12'd1;
            end
            px_cnt_q <= href_rise ? 12'd0 : px_cnt_inc;
            if (href_fall) begin
                last_px_q <= px_cnt_inc;
            end else if (frame_done) begin
                last_px_q <= 12'd0;
            end
            if (load_report) begin
                rep_frame_q <= frame_cnt_inc;
                rep_line_q  <= line_cnt_q;
                rep_px_q    <= last_px_q;
            end
            overrun_q <= report_due && (state_q != StIdle);
        end
    end

`ifdef CMOS_REPORT_LUMA_EN
    logic [6:0] luma, max_luma_q, rep_luma_q;

    assign luma = 7'(I_pix_data[15:11]) + 7'(I_pix_data[10:5]) + 7'(I_pix_data[4:0]);

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            max_luma_q <= '0;
            rep_luma_q <= '0;
        end else begin
            if (frame_done) begin
                max_luma_q <= pix_ok ? luma : 7'd0;
            end else if (pix_ok && luma > max_luma_q) begin
                max_luma_q <= luma;
            end
            if (load_report) begin
                rep_luma_q <= max_luma_q;
            end
        end
    end
`else
    logic unused_pix_data;
    assign unused_pix_data = ^I_pix_data;
`endif

    always_comb begin
        msg_byte = ASCII_SP;
        case (idx_q)
            5'd0:    msg_byte = ASCII_F;
            5'd1:    msg_byte = ASCII_EQ;
            5'd2:    msg_byte = nibble_to_hex(rep_frame_q[15:12]);
            5'd3:    msg_byte = nibble_to_hex(rep_frame_q[11:8]);
            5'd4:    msg_byte = nibble_to_hex(rep_frame_q[7:4]);
            5'd5:    msg_byte = nibble_to_hex(rep_frame_q[3:0]);
            5'd7:    msg_byte = ASCII_L;
            5'd8:    msg_byte = ASCII_EQ;
            5'd9:    msg_byte = nibble_to_hex(rep_line_q[11:8]);
            5'd10:   msg_byte = nibble_to_hex(rep_line_q[7:4]);
            5'd11:   msg_byte = nibble_to_hex(rep_line_q[3:0]);
            5'd13:   msg_byte = ASCII_P;
            5'd14:   msg_byte = ASCII_EQ;
            5'd15:   msg_byte = nibble_to_hex(rep_px_q[11:8]);
            5'd16:   msg_byte = nibble_to_hex(rep_px_q[7:4]);
            5'd17:   msg_byte = nibble_to_hex(rep_px_q[3:0]);
`ifdef CMOS_REPORT_LUMA_EN
            5'd19:   msg_byte = ASCII_Y;
            5'd20:   msg_byte = ASCII_EQ;
            5'd21:   msg_byte = nibble_to_hex({1'b0, rep_luma_q[6:4]});
            5'd22:   msg_byte = nibble_to_hex(rep_luma_q[3:0]);
            5'd23:   msg_byte = ASCII_CR;
            5'd24:   msg_byte = ASCII_LF;
`else
            5'd18:   msg_byte = ASCII_CR;
            5'd19:   msg_byte = ASCII_LF;
`endif
            default: msg_byte = ASCII_SP;
        endcase
    end

    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tx_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (report_due) begin
                    state_d = StSend;
                    idx_d   = 5'd0;
                end
            end
            StSend: begin
                tx_start = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    uart_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_byte_tx (
        .I_pxl_clk (I_pxl_clk),
        .I_rst     (I_rst),
        .I_data    (msg_byte),
        .I_start   (tx_start),
        .O_done    (tx_done),
        .O_tx      (O_uart_tx)
    );

    assign O_busy      = (state_q != StIdle);
    assign O_frame_cnt = frame_cnt_q;
    assign O_overrun   = overrun_q;

endmodule

// File: tb/tb_cmos_frame_reporter.sv
// Directed bench for cmos_frame_reporter: frame-level model, UART decoder and scoreboard.
module tb_cmos_frame_reporter;

    localparam int unsigned CLK_DIV      = 4;
    localparam int unsigned REPORT_EVERY = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0, href = 1'b0, pv = 1'b0;
    logic [15:0] pd = 16'h0;
    logic        tx, busy, ovr;
    logic [15:0] fc;

    always #5 clk = ~clk;

    cmos_frame_reporter #(
        .CLK_DIV      (CLK_DIV),
        .REPORT_EVERY (REPORT_EVERY)
    ) dut (
        .I_pxl_clk   (clk),
        .I_rst       (rst),
        .I_vsync     (vsync),
        .I_href      (href),
        .I_pix_valid (pv),
        .I_pix_data  (pd),
        .O_uart_tx   (tx),
        .O_busy      (busy),
        .O_frame_cnt (fc),
        .O_overrun   (ovr)
    );

    int errors = 0;
    int checks = 0;

    // Frame-level model state
    int          m_lines = 0, m_last_px = 0, m_max = 0;
    logic [15:0] exp_fc = 16'h0;
    logic [7:0]  exp_q[$];
    bit          drop_mode = 1'b0;
    int          exp_ovr = 0;

    // Decoder / monitor state
    bit          chk_en = 1'b0;
    string       rx_lines[$];
    string       cur = "";
    bit          rx_on = 1'b0;
    int          rx_t = 0, cyc = 0, last_start = 0, ovr_pulses = 0;
    logic [7:0]  rx_sh = 8'h0;
    logic        ovr_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic int luma_of(input logic [15:0] p);
        return int'(p[15:11]) + int'(p[10:5]) + int'(p[4:0]);
    endfunction

    function automatic string hex_str(input int v, input int nd);
        string digits = "0123456789ABCDEF";
        string s = "";
        for (int i = nd - 1; i >= 0; i--) begin
            s = $sformatf("%s%c", s, digits[(v >> (4 * i)) & 15]);
        end
        return s;
    endfunction

    function automatic string ysuf(input string y);
`ifdef CMOS_REPORT_LUMA_EN
        return {" Y=", y};
`else
        return "";
`endif
    endfunction

    function automatic string make_msg(input int f, input int l, input int p, input int y);
        return {"F=", hex_str(f, 4), " L=", hex_str(l, 3), " P=", hex_str(p, 3),
                ysuf(hex_str(y, 2))};
    endfunction

    task automatic push_msg(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int npx, input logic [15:0] data);
        href = 1'b1;
        pv   = 1'b0;
        tick();
        m_lines = (m_lines < 4095) ? m_lines + 1 : 4095;
        for (int i = 0; i < npx; i++) begin
            pv = 1'b1;
            pd = data;
            tick();
        end
        pv   = 1'b0;
        href = 1'b0;
        tick();
        m_last_px = (npx > 4095) ? 4095 : npx;
        if (npx > 0 && luma_of(data) > m_max) m_max = luma_of(data);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick();
        if (m_lines != 0) begin
            exp_fc = exp_fc + 16'd1;
            if ((exp_fc % REPORT_EVERY) == 0) begin
                if (drop_mode) exp_ovr++;
                else push_msg(make_msg(int'(exp_fc), m_lines, m_last_px, m_max));
            end
            m_lines   = 0;
            m_last_px = 0;
            m_max     = 0;
        end
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic frame(input int nlines, input int npx, input logic [15:0] data);
        for (int i = 0; i < nlines; i++) drive_line(npx, data);
        vsync_pulse();
    endtask

    task automatic wait_idle();
        int n = 0;
        tick();
        while ((busy || rx_on) && n < 5000) begin
            tick();
            n++;
        end
        check("idle wait timeout", 32'(n < 5000), 32'd1);
        repeat (5) tick();
    endtask

    // Per-cycle monitor and UART decoder
    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            check("frame_cnt", 32'(fc), 32'(exp_fc));
            if (ovr) begin
                if (ovr_prev) check("overrun width", 32'd2, 32'd1);
                else ovr_pulses++;
            end
            ovr_prev = ovr;
            if (rx_on && !rst) check("busy during byte", 32'(busy), 32'd1);
            if (rst) begin
                rx_on = 1'b0;
                cur   = "";
            end else if (!rx_on) begin
                if (tx == 1'b0) begin
                    rx_on = 1'b1;
                    rx_t  = 0;
                    if (cur.len() > 0)
                        check("byte spacing",
                              32'((cyc - last_start == 10 * CLK_DIV) ||
                                  (cyc - last_start == 10 * CLK_DIV + 1)), 32'd1);
                    last_start = cyc;
                end
            end else begin
                rx_t++;
                if ((rx_t % CLK_DIV) == CLK_DIV / 2) begin
                    int k;
                    k = rx_t / CLK_DIV;
                    if (k == 0) begin
                        check("start bit", 32'(tx), 32'd0);
                    end else if (k <= 8) begin
                        rx_sh[k-1] = tx;
                    end else begin
                        check("stop bit", 32'(tx), 32'd1);
                        rx_on = 1'b0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected uart byte: got %0h expected none", rx_sh);
                        end else begin
                            check("uart byte", 32'(rx_sh), 32'(exp_q.pop_front()));
                        end
                        if (rx_sh == 8'h0A) begin
                            rx_lines.push_back(cur);
                            cur = "";
                        end else if (rx_sh != 8'h0D) begin
                            cur = $sformatf("%s%c", cur, rx_sh);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int n_lines;
        bit idle_bad;

        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset uart_tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_cnt", 32'(fc), 32'd0);
        check("reset overrun", 32'(ovr), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        // Three 5x8 white frames
        for (int f = 0; f < 3; f++) begin
            frame(5, 8, 16'hFFFF);
            wait_idle();
        end

        // Seven lines, last one 1000 pixels
        for (int i = 0; i < 6; i++) drive_line(8, 16'h1234);
        drive_line(1000, 16'h0841);
        vsync_pulse();
        wait_idle();

        // Line count saturation
        frame(4100, 1, 16'hF800);
        wait_idle();

        // Vsync with no lines
        n_lines  = rx_lines.size();
        idle_bad = 1'b0;
        vsync_pulse();
        for (int i = 0; i < 200; i++) begin
            if (!tx || busy) idle_bad = 1'b1;
            tick();
        end
        check("empty vsync quiet line", 32'(idle_bad), 32'd0);
        check("empty vsync no report", 32'(rx_lines.size()), 32'(n_lines));
        check("empty vsync frame_cnt", 32'(fc), 32'd5);

        // Short frames during an in-flight report get dropped
        frame(2, 3, 16'hFFFF);
        drop_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame(1, 1, 16'hFFFF);
            repeat (4) tick();
        end
        drop_mode = 1'b0;
        check("frame_cnt after drops", 32'(fc), 32'd9);
        wait_idle();
        check("overrun pulses", 32'(ovr_pulses), 32'd3);
        check("overrun pulses vs model", 32'(ovr_pulses), 32'(exp_ovr));
        frame(2, 3, 16'hFFFF);
        wait_idle();

        // Reset during byte 12 of a report
        frame(2, 3, 16'hFFFF);
        n = 0;
        while (!(rx_on && cur.len() == 11) && n < 2000) begin
            tick();
            n++;
        end
        check("reach byte 12 timeout", 32'(n < 2000), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        exp_fc    = 16'h0;
        m_lines   = 0;
        m_last_px = 0;
        m_max     = 0;
        @(negedge clk);
        check("abort uart_tx", 32'(tx), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort frame_cnt", 32'(fc), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        frame(2, 3, 16'hFFFF);
        wait_idle();

        check("all expected bytes sent", 32'(exp_q.size()), 32'd0);
        check("report count", 32'(rx_lines.size()), 32'd8);
        if (rx_lines.size() == 8) begin
            check_str("report 1", rx_lines[0], {"F=0001 L=005 P=008", ysuf("7D")});
            check_str("report 2", rx_lines[1], {"F=0002 L=005 P=008", ysuf("7D")});
            check_str("report 3", rx_lines[2], {"F=0003 L=005 P=008", ysuf("7D")});
            check_str("report long line", rx_lines[3], {"F=0004 L=007 P=3E8", ysuf("27")});
            check_str("report saturated", rx_lines[4], {"F=0005 L=FFF P=001", ysuf("1F")});
            check_str("report in flight", rx_lines[5], {"F=0006 L=002 P=003", ysuf("7D")});
            check_str("report after drops", rx_lines[6], {"F=000A L=002 P=003", ysuf("7D")});
            check_str("report after reset", rx_lines[7], {"F=0001 L=002 P=003", ysuf("7D")});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmos_frame_reporter.md
Name: cmos_frame_reporter

Overview:
- Sits directly downstream of the OV5640 capture stage and consumes its pixel-valid strobe, 16-bit RGB565 pixel word, href and vsync.
- Measures per-frame geometry: lines per frame, pixels in the last line, and peak luma.
- Every REPORT_EVERY frames it serialises one fixed-format ASCII report onto the board's uart_tx pin, for bring-up without a logic analyser.
- Runs entirely in the camera pixel-clock domain.

Parameters:
- CLK_DIV, 365: pixel-clock cycles per UART bit. 42 MHz / 115200 baud.
- REPORT_EVERY, 16: a report is started when frame_cnt mod REPORT_EVERY == 0. Legal range 1..65535.

Ports:
- I_pxl_clk  in  1  camera pixel clock; single clock for the block.
- I_rst  in  1  reset; synchronous, active-high.
- I_vsync  in  1  camera vsync; rising edge marks a frame boundary.
- I_href  in  1  line-active qualifier.
- I_pix_valid  in  1  one-cycle strobe per assembled pixel.
- I_pix_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0].
- O_uart_tx  out  1  8N1 serial output; idle high.
- O_busy  out  1  high while a report is being transmitted.
- O_frame_cnt  out  16  completed-frame counter.
- O_overrun  out  1  one-cycle pulse when a due report is dropped because the transmitter is busy.

Behaviour:
- Reset: O_uart_tx=1, O_busy=0, O_frame_cnt=0, O_overrun=0. All counters, snapshots and edge-detect registers clear. Reset mid-transmission aborts the report immediately; the line returns to idle 1 on the next cycle.
- Edge detect: I_vsync and I_href are registered once. A rise is defined as cur & ~prev, a fall as ~cur & prev. All edge actions occur in the cycle after the input edge.
- Line counting:
  - line_cnt (12 bit) increments on each href rise.
  - It saturates at 4095 and does not wrap.
- Pixel counting:
  - px_cnt (12 bit) clears on each href rise.
  - It increments on I_pix_valid only while the registered href is high, and saturates at 4095.
  - On an href fall, last_px <= px_cnt, including any same-cycle increment.
  - I_pix_valid while href is low is ignored.
- Luma:
  - luma = R + G + B, zero-extended to 7 bits (max 125).
  - max_luma tracks the maximum over valid in-line pixels of the current frame.
- Frame boundary (vsync rise):
  - If line_cnt != 0, the frame is complete:
    - O_frame_cnt increments, wrapping at 16 bits.
    - Snapshot {new frame_cnt, line_cnt, last_px, max_luma}.
    - line_cnt, max_luma and last_px clear.
  - If line_cnt == 0: no count, no snapshot.
  - If vsync rise and href rise land in the same cycle, the frame boundary is processed first; that line counts in the new frame (line_cnt = 1 afterwards).
- Report trigger: a completed frame whose new count satisfies mod REPORT_EVERY == 0 makes a report due.
  - Transmitter idle: load the snapshot and go to SEND.
  - Transmitter busy: pulse O_overrun for 1 cycle; the snapshot is discarded.
- Message format: "F=hhhh L=hhh P=hhh Y=hh" followed by CR LF, 25 bytes.
  - Hex digits are upper-case ASCII, MSB digit first.
  - Y is {1'b0, max_luma} rendered as 2 hex digits.
- Formatter FSM:
  - States: IDLE -> SEND (issue byte[idx] to the byte transmitter) -> WAIT (until byte done).
  - From WAIT: go to SEND while idx < last; go to IDLE after the LF byte.
  - O_busy = (state != IDLE).
- UART framing:
  - Start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLK_DIV cycles.
  - Consecutive bytes are separated by at most 1 idle cycle.
  - O_uart_tx is registered.

Optional Feature:
- Macro: CMOS_REPORT_LUMA_EN.
- Defined: luma logic is present, and the message is 25 bytes including " Y=hh".
- Undefined: no luma datapath, and the message is "F=hhhh L=hhh P=hhh" followed by CR LF (20 bytes). All other behaviour is identical.

Decomposition:
- Package cmos_report_pkg holds:
  - message length constants MSG_LEN_LUMA=25 and MSG_LEN_BASE=20;
  - the ASCII constants '=', ' ', 'F', 'L', 'P', 'Y', CR, LF;
  - the nibble-to-hex function;
  - the formatter state enum.
- One sub-module: uart_byte_tx.
  - Interface: I_pxl_clk, I_rst, I_data[7:0], I_start, O_done (1-cycle pulse after the stop bit), O_tx.
  - Implementation: bit counter plus CLK_DIV divider.

Test Plan:
- Setup for all scenarios: CLK_DIV=4, REPORT_EVERY=1.
- 3 frames of 5 lines x 8 pixels, all pixels 16'hFFFF -> decoded UART strings "F=0001 L=005 P=008 Y=7D" then CR LF, followed by F=0002 and F=0003 reports.
- Line 7 of a frame has 1000 pixels -> P=3E8. A frame of 4100 href pulses -> L=FFF (saturated).
- Vsync rise with no lines -> no increment, no UART activity, O_frame_cnt unchanged.
- Frames only 10 cycles long while a report is in flight -> O_overrun pulses once per dropped report; the in-flight bytes are undisturbed; O_frame_cnt still increments.
- Assert I_rst during byte 12 of a report -> next cycle O_uart_tx=1, O_busy=0, O_frame_cnt=0; the next complete frame reports "F=0001".
- Build without CMOS_REPORT_LUMA_EN, one frame of 2 lines x 3 pixels -> exactly 20 bytes: "F=0001 L=002 P=003" then CR LF.
